// File: rtl/spi_cmd_decoder_if.sv
// Word and frame-memory signals between the SPI slave, the command decoder
// and the frame buffer read port. The decoder side uses the slave modport.
interface spi_cmd_decoder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17
);
  logic [DATA_W-1:0] wordIN;
  logic              wordValidIN;
  logic              nSSIN;
  logic [DATA_W-1:0] replyOUT;
  logic [ADDR_W-1:0] memAddrOUT;
  logic              memRdOUT;
  logic [DATA_W-1:0] memDataIN;

  modport slave (
    input  wordIN, wordValidIN, nSSIN, memDataIN,
    output replyOUT, memAddrOUT, memRdOUT
  );

  modport master (
    output wordIN, wordValidIN, nSSIN, memDataIN,
    input  replyOUT, memAddrOUT, memRdOUT
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: register reads/writes, frame-buffer burst reads and
// the reply word handed back to the SPI slave for the next transfer.
module spi_cmd_decoder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17
) (
  input  logic                    clkIN,
  input  logic                    nRESETIN,
  spi_cmd_decoder_if.slave        bus,
  output logic [7:0]              ctrlOUT,
  output logic                    errorOUT
);

  typedef enum logic [1:0] {IDLE, MEMRD, MEMWAIT, BURST} state_t;

  state_t            state, state_next;
  logic              word_valid_q;
  logic              nss_s1, nss_s2, nss_s3;
  logic              word_event, deselect;
  logic [7:0]        regs [0:7];
  logic [5:0]        errcnt;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [11:0]       remaining, remaining_next;
  logic [DATA_W-1:0] reply, reply_next;
  logic              err_now, reg_we, mem_rd;
  logic [3:0]        opcode;
  logic [11:0]       arg;
  logic [2:0]        reg_idx;
  logic [7:0]        rd_data;

  assign opcode     = bus.wordIN[DATA_W-1 -: 4];
  assign arg        = bus.wordIN[DATA_W-5 -: 12];
  assign reg_idx    = arg[10:8];
  assign word_event = bus.wordValidIN & ~word_valid_q;
  assign deselect   = nss_s2 & ~nss_s3;
  // Reg 7 is never stored; it is assembled from live status on every read.
  assign rd_data    = (reg_idx == 3'd7) ? {(state != IDLE), 1'b0, errcnt} : regs[reg_idx];

  // Synchronizers reset to the deselected level so reset alone never looks like a deselect.
  always_ff @(posedge clkIN or negedge nRESETIN) begin
    if (!nRESETIN) begin
      nss_s1       <= 1'b1;
      nss_s2       <= 1'b1;
      nss_s3       <= 1'b1;
      word_valid_q <= 1'b0;
    end else begin
      nss_s1       <= bus.nSSIN;
      nss_s2       <= nss_s1;
      nss_s3       <= nss_s2;
      word_valid_q <= bus.wordValidIN;
    end
  end

  always_ff @(posedge clkIN or negedge nRESETIN) begin
    if (!nRESETIN) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next     = state;
    reply_next     = reply;
    addr_next      = addr;
    remaining_next = remaining;
    err_now        = 1'b0;
    reg_we         = 1'b0;
    mem_rd         = 1'b0;
    if (deselect) begin
      state_next = IDLE;
      reply_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (word_event) begin
            case (opcode)
              4'h0: reply_next = '0;
              4'h1: begin
                reg_we     = 1'b1;
                reply_next = {{(DATA_W-8){1'b0}}, arg[7:0]};
              end
              4'h2: reply_next = {{(DATA_W-8){1'b0}}, rd_data};
              4'h3: begin
                addr_next[11:0] = arg;
                reply_next      = '0;
              end
              4'h4: begin
                addr_next[ADDR_W-1:12] = arg[ADDR_W-13:0];
                reply_next             = '0;
              end
              4'h5: begin
                if (arg == 12'd0) begin
                  reply_next = '0;
                end else begin
                  remaining_next = arg;
                  state_next     = MEMRD;
                end
              end
              default: begin
                reply_next = '1;
                err_now    = 1'b1;
              end
            endcase
          end
        end
        MEMRD: begin
          mem_rd     = 1'b1;
          err_now    = word_event;
          state_next = MEMWAIT;
        end
        MEMWAIT: begin
          err_now        = word_event;
          reply_next     = bus.memDataIN;
          addr_next      = addr + ADDR_W'(1);
          remaining_next = remaining - 12'd1;
          state_next     = BURST;
        end
        BURST: begin
          if (word_event) begin
            if (remaining != 12'd0) begin
              state_next = MEMRD;
            end else begin
              state_next = IDLE;
              reply_next = '0;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkIN or negedge nRESETIN) begin
    if (!nRESETIN) begin
      reply     <= '0;
      addr      <= '0;
      remaining <= '0;
      errorOUT  <= 1'b0;
      errcnt    <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      reply     <= reply_next;
      addr      <= addr_next;
      remaining <= remaining_next;
      errorOUT  <= err_now;
      if (reg_we && reg_idx != 3'd7) regs[reg_idx] <= arg[7:0];
      if (reg_we && reg_idx == 3'd7)          errcnt <= '0;
      else if (err_now && errcnt != 6'd63)    errcnt <= errcnt + 6'd1;
    end
  end

  assign bus.replyOUT   = reply;
  assign bus.memAddrOUT = addr;
  assign bus.memRdOUT   = mem_rd;
  assign ctrlOUT        = regs[0];

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Randomized bench for spi_cmd_decoder against a word-level protocol model.
module tb_spi_cmd_decoder;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 17;

  logic       clkIN = 1'b0;
  logic       nRESETIN;
  logic [7:0] ctrlOUT;
  logic       errorOUT;

  spi_cmd_decoder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  spi_cmd_decoder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clkIN    (clkIN),
    .nRESETIN (nRESETIN),
    .bus      (bus.slave),
    .ctrlOUT  (ctrlOUT),
    .errorOUT (errorOUT)
  );

  always #5 clkIN = ~clkIN;

  int nChecks = 0;
  int nFail   = 0;
  int errPulses = 0;
  int expErrPulses = 0;

  // Word-level model of the decoder
  logic [7:0]        mRegs [8];
  int                mErr;
  logic [ADDR_W-1:0] mAddr;
  bit                mInBurst;
  int                mLeft;
  logic [DATA_W-1:0] expReply;
  logic [ADDR_W-1:0] expAddrQ [$];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] memFn(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ {a[16], a[16:2]} ^ 16'h5A3C;
  endfunction

  // Frame memory: data for a request shows up one cycle after memRdOUT.
  logic              prevRd = 1'b0;
  logic [ADDR_W-1:0] prevAddr = '0;
  always @(negedge clkIN) begin
    bus.memDataIN = prevRd ? memFn(prevAddr) : 16'($urandom);
    prevRd   = bus.memRdOUT;
    prevAddr = bus.memAddrOUT;
  end

  always @(negedge clkIN) begin
    if (errorOUT) errPulses++;
    if (bus.memRdOUT) begin
      if (expAddrQ.size() == 0) checkOutput("memrd_spurious", 32'(bus.memAddrOUT), 32'h1FFFFFFF);
      else checkOutput("memaddr", 32'(bus.memAddrOUT), 32'(expAddrQ.pop_front()));
    end
  end

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mRegs[i] = 8'h00;
    mErr = 0; mAddr = '0; mInBurst = 0; mLeft = 0; expReply = '0;
    expAddrQ.delete();
  endtask

  task automatic modelError();
    expErrPulses++;
    if (mErr < 63) mErr++;
  endtask

  task automatic modelFetch();
    expAddrQ.push_back(mAddr);
    expReply = memFn(mAddr);
    mAddr++;
    mLeft--;
  endtask

  task automatic modelWord(input logic [15:0] w);
    logic [3:0]  op;
    logic [11:0] arg;
    logic [2:0]  idx;
    op = w[15:12]; arg = w[11:0]; idx = arg[10:8];
    if (mInBurst) begin
      if (mLeft > 0) modelFetch();
      else begin expReply = '0; mInBurst = 0; end
    end else begin
      case (op)
        4'h0: expReply = '0;
        4'h1: begin
          if (idx == 3'd7) mErr = 0; else mRegs[idx] = arg[7:0];
          expReply = {8'h00, arg[7:0]};
        end
        4'h2: expReply = (idx == 3'd7) ? {8'h00, 2'b00, 6'(mErr)} : {8'h00, mRegs[idx]};
        4'h3: begin mAddr[11:0] = arg; expReply = '0; end
        4'h4: begin mAddr[16:12] = arg[4:0]; expReply = '0; end
        4'h5: begin
          if (arg == 12'd0) expReply = '0;
          else begin mInBurst = 1; mLeft = int'(arg); modelFetch(); end
        end
        default: begin expReply = '1; modelError(); end
      endcase
    end
  endtask

  task automatic applyStimulus(input logic [15:0] w);
    modelWord(w);
    @(negedge clkIN);
    bus.wordIN = w;
    bus.wordValidIN = 1'b1;
    repeat (2) @(negedge clkIN);
    bus.wordValidIN = 1'b0;
    repeat (6) @(negedge clkIN);
  endtask

  task automatic checkAfterWord(input string tag);
    checkOutput({tag, "_reply"}, 32'(bus.replyOUT), 32'(expReply));
    checkOutput({tag, "_ctrl"}, 32'(ctrlOUT), 32'(mRegs[0]));
    checkOutput({tag, "_errcount"}, 32'(errPulses), 32'(expErrPulses));
    checkOutput({tag, "_pendrd"}, 32'(expAddrQ.size()), 32'd0);
  endtask

  task automatic sendCheck(input logic [15:0] w, input string tag);
    applyStimulus(w);
    checkAfterWord(tag);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] w;
    int r;
    modelReset();
    nRESETIN = 1'b0;
    bus.nSSIN = 1'b0;
    bus.wordValidIN = 1'b0;
    bus.wordIN = '0;
    repeat (3) @(negedge clkIN);
    checkOutput("rst_reply", 32'(bus.replyOUT), 32'd0);
    checkOutput("rst_memaddr", 32'(bus.memAddrOUT), 32'd0);
    checkOutput("rst_memrd", 32'(bus.memRdOUT), 32'd0);
    checkOutput("rst_ctrl", 32'(ctrlOUT), 32'd0);
    checkOutput("rst_error", 32'(errorOUT), 32'd0);
    nRESETIN = 1'b1;
    repeat (3) @(negedge clkIN);

    $display("[TB] register write/read");
    sendCheck(16'h1312, "wrreg3");
    checkOutput("wrreg3_echo", 32'(bus.replyOUT), 32'h0012);
    sendCheck(16'h2300, "rdreg3");
    checkOutput("rdreg3_const", 32'(bus.replyOUT), 32'h0012);
    checkOutput("ctrl_untouched", 32'(ctrlOUT), 32'h00);

    $display("[TB] burst across address wrap");
    sendCheck(16'h3FFE, "setlo");
    sendCheck(16'h401F, "sethi");
    checkOutput("sethi_addr", 32'(bus.memAddrOUT), 32'h1FFFE);
    sendCheck(16'h5003, "burst_w1");
    for (int i = 0; i < 3; i++) sendCheck(16'($urandom), "burst_dummy");
    checkOutput("burst_final_zero", 32'(bus.replyOUT), 32'd0);
    checkOutput("burst_addr_wrap", 32'(bus.memAddrOUT), 32'h00001);

    $display("[TB] illegal opcode");
    sendCheck(16'hF000, "illegal");
    checkOutput("illegal_ones", 32'(bus.replyOUT), 32'hFFFF);
    sendCheck(16'h2700, "status");
    checkOutput("status_const", 32'(bus.replyOUT), 32'h0001);

    $display("[TB] deselect abort");
    sendCheck(16'h5008, "abort_w1");
    sendCheck(16'h0000, "abort_d1");
    sendCheck(16'h0000, "abort_d2");
    @(negedge clkIN);
    bus.nSSIN = 1'b1;
    repeat (6) @(negedge clkIN);
    mInBurst = 0; mLeft = 0; expReply = '0;
    checkAfterWord("abort");
    bus.nSSIN = 1'b0;
    repeat (4) @(negedge clkIN);
    sendCheck(16'h2700, "abort_status");

    $display("[TB] word collision during fetch");
    modelWord(16'h5002);
    @(negedge clkIN);
    bus.wordIN = 16'h5002;
    bus.wordValidIN = 1'b1;
    @(negedge clkIN);
    bus.wordValidIN = 1'b0;
    @(negedge clkIN);
    bus.wordIN = 16'h1055;
    bus.wordValidIN = 1'b1;
    @(negedge clkIN);
    bus.wordValidIN = 1'b0;
    modelError();
    repeat (6) @(negedge clkIN);
    checkAfterWord("collide_w1");
    sendCheck(16'h0000, "collide_w2");
    sendCheck(16'h0000, "collide_end");

    $display("[TB] error counter saturation");
    for (int i = 0; i < 70; i++) applyStimulus({4'($urandom_range(6, 15)), 12'($urandom)});
    sendCheck(16'h2700, "errsat");
    checkOutput("errsat_const", 32'(bus.replyOUT), 32'h003F);
    sendCheck(16'h17A5, "errclr");
    sendCheck(16'h2700, "errclr_rd");

    $display("[TB] randomized commands");
    for (int i = 0; i < 200; i++) begin
      if (mInBurst) w = 16'($urandom);
      else begin
        r = $urandom_range(0, 9);
        case (r)
          0: w = {4'h0, 12'($urandom)};
          1, 2: w = {4'h1, 12'($urandom)};
          3, 4: w = {4'h2, 12'($urandom)};
          5: w = {4'h3, 12'($urandom)};
          6: w = {4'h4, 12'($urandom)};
          7, 9: w = {4'h5, 12'($urandom_range(0, 5))};
          default: w = {4'($urandom_range(6, 15)), 12'($urandom)};
        endcase
      end
      sendCheck(w, "rand");
    end

    $display("[TB] reset during burst");
    while (mInBurst) sendCheck(16'h0000, "drain");
    sendCheck(16'h10AB, "ctrl_set");
    sendCheck(16'h5004, "rstb_w1");
    @(negedge clkIN);
    bus.wordIN = 16'h0000;
    bus.wordValidIN = 1'b1;
    @(posedge clkIN);
    #2;
    checkOutput("memrd_before_reset", 32'(bus.memRdOUT), 32'd1);
    nRESETIN = 1'b0;
    #1;
    checkOutput("arst_reply", 32'(bus.replyOUT), 32'd0);
    checkOutput("arst_memaddr", 32'(bus.memAddrOUT), 32'd0);
    checkOutput("arst_memrd", 32'(bus.memRdOUT), 32'd0);
    checkOutput("arst_ctrl", 32'(ctrlOUT), 32'd0);
    checkOutput("arst_error", 32'(errorOUT), 32'd0);
    @(negedge clkIN);
    bus.wordValidIN = 1'b0;
    repeat (3) @(negedge clkIN);
    nRESETIN = 1'b1;
    modelReset();
    repeat (2) @(negedge clkIN);
    sendCheck(16'h0000, "post_rst_nop");
    sendCheck(16'h2700, "post_rst_status");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Command decoder and reply generator sitting directly downstream of the SPI slave. It consumes each received SPI word and its received strobe, executes register writes, register reads and frame-memory burst reads, and drives the next word the slave shifts out on MISO. It owns the small control register bank and the read port into the thermal frame buffer.

## Interface
- DATA_W, 16, SPI word width; equals the SPI slave word width.
- ADDR_W, 17, frame-buffer word address width (13..24).
- clkIN  in  1  system clock; every flop in the block is clocked here.
- nRESETIN  in  1  asynchronous active-low reset.
- wordIN  in  DATA_W  last received SPI word; stable while wordValidIN is high.
- wordValidIN  in  1  received-word strobe from the SPI slave, clkIN domain; high for one or more cycles per word.
- nSSIN  in  1  SPI chip select, asynchronous, active-low.
- replyOUT  out  DATA_W  word loaded into the SPI slave for the next transfer.
- memAddrOUT  out  ADDR_W  frame-buffer read address.
- memRdOUT  out  1  one-cycle read request.
- memDataIN  in  DATA_W  read data, valid exactly 1 cycle after memRdOUT.
- ctrlOUT  out  8  contents of register 0, the control register.
- errorOUT  out  1  one-cycle pulse per protocol error.

## Operation
- Word format: opcode = wordIN[15:12], arg = wordIN[11:0], with DATA_W = 16. For other widths the opcode is the top 4 bits and arg is the next 12 bits.
- A word event is the rising edge of wordValidIN. The level is ignored after the edge.
- nSSIN passes through a 2-flop synchronizer. A synchronized rising edge (deselect) aborts any operation: state returns to IDLE, replyOUT = 0, memRdOUT = 0.
- Register bank: 8 x 8 bits.
  - Regs 0..6 are read/write.
  - Reg 7 is read-only status {burst_active, 0, errcnt[5:0]}. errcnt saturates at 63 and is cleared by a write of any value to reg 7.
- Opcodes:
  - 0x0 NOP: replyOUT = 0.
  - 0x1 WRREG: reg[arg[10:8]] <= arg[7:0]. replyOUT = {echo of the written data, zero-extended}.
  - 0x2 RDREG: replyOUT = reg[arg[10:8]], zero-extended.
  - 0x3 SETLO: addr[11:0] <= arg. replyOUT = 0.
  - 0x4 SETHI: addr[ADDR_W-1:12] <= arg[ADDR_W-13:0]. replyOUT = 0.
  - 0x5 BURST: n = arg. If n = 0, behave as NOP. Otherwise return n consecutive frame words starting at addr.
  - Any other opcode: replyOUT = all ones, errorOUT pulse, errcnt++.
- States:
  - IDLE: on a word event, decode. BURST with n > 0 goes to MEMRD; every other opcode completes in the event cycle and stays in IDLE.
  - MEMRD: memRdOUT = 1 for 1 cycle with the current addr; go to MEMWAIT.
  - MEMWAIT: replyOUT <= memDataIN; addr <= addr + 1, wrapping modulo 2^ADDR_W; remaining <= remaining - 1; go to BURST.
  - BURST: received words are dummies and their content is ignored. On a word event: if remaining != 0, go to MEMRD; else go to IDLE with replyOUT = 0.
- A burst of n therefore returns exactly n words: word 1 during the transfer after the command, word n during the n-th transfer after it.
- addr persists across bursts. After a burst of n from A, addr = A + n (mod 2^ADDR_W).
- A word event while in MEMRD or MEMWAIT is dropped and raises errorOUT plus errcnt++. The burst continues.

## Timing
- Reset values: replyOUT = 0, memAddrOUT = 0, memRdOUT = 0, ctrlOUT = 0, errorOUT = 0, all registers = 0, addr = 0, state = IDLE.
- Non-burst reply: replyOUT updates on the clock edge 1 cycle after the rising edge of wordValidIN is sampled.
- Burst reply: replyOUT updates 3 cycles after the edge (detect, MEMRD, MEMWAIT).
- The SPI master must leave at least 4 clkIN cycles between the end of one word and the first SCK of the next.
- ctrlOUT follows reg 0 and changes in the same cycle as the write.
- Deselect abort takes effect within 3 cycles of nSSIN rising.
- Reset mid-burst returns every output to its reset value immediately, asynchronously.

## Test plan
- After reset, send WRREG 0x1312 then RDREG 0x2300 -> ctrlOUT unchanged (reg 3 written, not reg 0); reply to RDREG = 0x0012.
- Send SETLO 0x3FFE, SETHI 0x401F, then BURST 0x5003 plus 3 dummies -> memAddrOUT sequence 0x1FFFE, 0x1FFFF, 0x00000 (wrap); replies equal the memory model data; final reply = 0.
- Send opcode 0xF000 -> replyOUT = 0xFFFF, one errorOUT pulse; RDREG 0x2700 -> reply 0x0001.
- Start BURST 0x5008 and raise nSSIN after 2 dummies -> state IDLE, replyOUT = 0, no further memRdOUT pulses.
- Issue a word event 1 cycle after a burst MEMRD -> errorOUT pulses and the burst still returns correct data.
- Assert nRESETIN mid-burst -> all outputs 0 asynchronously; NOP afterwards replies 0.
